// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int          INST_W           = 32;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: memory request/response, redirect and decoded-side output stream.
interface inst_fetch_if #(parameter int XLEN = 32);

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;

    modport master (
        output mem_req, mem_addr, out_valid, out_inst, out_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_inst, out_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; flush empties it at the next edge.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential prefetch into a small FIFO, with redirect and stale-response discard.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = CW + 2;
    localparam int EW = XLEN + INST_W;

    logic            run;
    logic [XLEN-1:0] fetch_pc, rsp_pc, redir_pc;
    logic [CW-1:0]   outstanding, fifo_count;
    logic [DW-1:0]   discard;
    logic            grant, rsp_live, rsp_stale, fifo_empty, pop;
    logic [EW-1:0]   head;

    assign redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign grant     = bus.mem_req && bus.mem_gnt;
    assign rsp_stale = bus.mem_rvalid && (discard != '0);
    assign rsp_live  = bus.mem_rvalid && (discard == '0);
    assign pop       = bus.out_valid && bus.out_ready;

    // run holds requests off until the first edge after reset release.
    assign bus.mem_req  = run && !bus.redirect &&
                          ((int'(outstanding) + int'(fifo_count)) < DEPTH);
    assign bus.mem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run <= 1'b1;
            if (bus.redirect) begin
                fetch_pc    <= redir_pc;
                rsp_pc      <= redir_pc;
                outstanding <= '0;
                // Everything still in flight becomes stale, including a response landing now.
                discard     <= discard - DW'(rsp_stale) + DW'(outstanding)
                               - DW'(rsp_live) + DW'(grant);
            end else begin
                if (grant)    fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_live) rsp_pc   <= rsp_pc + XLEN'(4);
                outstanding <= outstanding + CW'(grant) - CW'(rsp_live);
                discard     <= discard - DW'(rsp_stale);
            end
        end
    end

    // Responses return in order, so the PC of each live response is just the running rsp_pc.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect),
        .push      (rsp_live && !bus.redirect),
        .push_data ({rsp_pc, bus.mem_rdata}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_inst  = bus.out_valid ? head[INST_W-1:0] : '0;
    assign bus.out_pc    = bus.out_valid ? head[EW-1:INST_W] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch against a program-order stream model.
module tb_inst_fetch;
    import riscv_pkg::*;

    localparam int          XLEN    = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.XLEN(XLEN)) bus ();
    inst_fetch_if #(.XLEN(XLEN)) wbus ();

    inst_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC))  dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    inst_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

    int n_vec = 0, n_err = 0, cyc = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1, gnt_cnt = 0;
    pend_t       pend[$];
    exp_t        exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] pop_log[$];
    logic [31:0] wlog[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + NOP_INST;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream: after reset or redirect, instructions appear in program order from the target.
    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{pc: pc + 32'(4 * i), inst: mem_word(pc + 32'(4 * i))});
        next_pc = pc + 32'd32;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: random grants, in-order responses with random latency.
    initial begin
        logic        stall_q;
        logic [31:0] addr_q;
        stall_q = 1'b0;
        addr_q  = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; stall_q = 1'b0;
            end else begin
                if (stall_q && bus.mem_req) chk("addr_hold", bus.mem_addr, addr_q);
                if (bus.mem_req) chk("addr_align", {30'b0, bus.mem_addr[1:0]}, 32'h0);
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = $urandom;
                end
                bus.mem_gnt = (int'($urandom_range(99)) < gnt_pct);
                if (bus.mem_req && bus.mem_gnt) begin
                    pend.push_back('{addr: bus.mem_addr,
                                     due: cyc + lat_min + int'($urandom_range(lat_max - lat_min))});
                    gnt_cnt++;
                end
                stall_q = bus.mem_req && !bus.mem_gnt;
                addr_q  = bus.mem_addr;
            end
        end
    end

    // Monitor: every consumer handshake is checked against the head of the expected stream.
    initial begin
        exp_t e;
        restart(RST_PC);
        forever begin
            @(negedge clk);
            if (!rst_n) restart(RST_PC);
            else begin
                if (bus.out_valid && bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_inst", bus.out_inst, e.inst);
                    pop_log.push_back(bus.out_pc);
                    while (exp_q.size() < 8) begin
                        exp_q.push_back('{pc: next_pc, inst: mem_word(next_pc)});
                        next_pc += 32'd4;
                    end
                end
                if (bus.redirect) restart({bus.redirect_pc[31:2], 2'b00});
            end
        end
    end

    // Wrap-around instance: always-grant memory, one-cycle response, always-ready consumer.
    initial begin
        logic        req_q;
        logic [31:0] waddr_q;
        req_q = 1'b0;
        waddr_q = '0;
        wbus.mem_gnt = 1'b1; wbus.mem_rvalid = 1'b0; wbus.mem_rdata = '0;
        wbus.redirect = 1'b0; wbus.redirect_pc = '0; wbus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_q = 1'b0;
                wbus.mem_rvalid = 1'b0;
            end else begin
                wbus.mem_rvalid = req_q;
                wbus.mem_rdata  = mem_word(waddr_q);
                if (wbus.out_valid && wlog.size() < 2) wlog.push_back(wbus.out_pc);
                req_q   = wbus.mem_req;
                waddr_q = wbus.mem_addr;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        gnt_cnt = 0;
        pop_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] want);
        int mark;
        @(posedge clk);
        #1 bus.redirect = 1'b1; bus.redirect_pc = tgt;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        mark = pop_log.size();
        @(negedge clk);
        chk("post_redirect_req", {31'b0, bus.mem_req}, 32'h1);
        chk("post_redirect_addr", bus.mem_addr, want);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("post_redirect_pc", (pop_log.size() > mark) ? pop_log[mark] : 32'hDEAD_BEEF, want);
    endtask

    initial begin
        int lat;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, RST_PC);
        chk("rst_wrap_addr", wbus.mem_addr, WRAP_PC);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);

        // Streaming from reset.
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin lat = k; break; end
        end
        chk("first_valid_latency", 32'(lat), 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("stream_pc", (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_BEEF, 32'(4 * i));
        chk("wrap_pc0", (wlog.size() > 0) ? wlog[0] : 32'hDEAD_BEEF, WRAP_PC);
        chk("wrap_pc1", (wlog.size() > 1) ? wlog[1] : 32'hDEAD_BEEF, 32'h0);

        // Backpressure: the FIFO fills and requests stop, then one request per pop.
        bus.out_ready = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_grants", 32'(gnt_cnt), 32'd4);
        chk("bp_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("bp_out_valid", {31'b0, bus.out_valid}, 32'h1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_grants_after_pop", 32'(gnt_cnt), 32'd5);
        chk("bp_mem_req_after_pop", {31'b0, bus.mem_req}, 32'h0);

        // Redirect with two responses in flight, then a misaligned target.
        bus.out_ready = 1'b1;
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (12) @(posedge clk);
        chk("pend_before_redirect", 32'(pend.size()), 32'd2);
        redirect_to(32'h0000_0100, 32'h0000_0100);
        redirect_to(32'h0000_0203, 32'h0000_0200);

        // Asynchronous reset mid-stream.
        lat_min = 3; lat_max = 3;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("mid_rst_mem_addr", bus.mem_addr, RST_PC);
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("mid_rst_out_inst", bus.out_inst, 32'h0);
        chk("mid_rst_out_pc", bus.out_pc, 32'h0);
        gnt_cnt = 0;
        pop_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("restart_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, RST_PC);

        // Random traffic: stalls, latency, backpressure and redirects (including back-to-back).
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        pop_log.delete();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready   = ($urandom_range(99) < 70);
            bus.redirect    = ($urandom_range(99) < 4);
            bus.redirect_pc = $urandom;
        end
        @(posedge clk);
        #1 bus.redirect = 1'b0; bus.out_ready = 1'b1; gnt_pct = 100;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("random_progress", {31'b0, pop_log.size() > 200}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
